// File: rtl/wb_arbiter.sv
// Writeback arbiter: serializes ALU results and buffered load results onto the
// single register-file write port and tracks pending destinations in a busy
// scoreboard for the issue stage.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     busy,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            full, empty, push, pop, commit;
    logic [4:0]      c_rd;
    logic [XLEN-1:0] c_data;
    logic [31:0]     clr_mask, set_mask, busy_nxt;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // Readies depend only on registered occupancy, never on the valids.
    assign alu_ready = !full;
    assign lsu_ready = !full;
    assign push      = lsu_valid && lsu_ready;

    // Pick one commit per cycle: a full FIFO forces a drain so loads cannot
    // starve behind a continuous ALU stream; otherwise ALU wins.
    always_comb begin
        pop    = 1'b0;
        commit = 1'b0;
        c_rd   = rd_mem[rd_ptr];
        c_data = data_mem[rd_ptr];
        if (full) begin
            pop    = 1'b1;
            commit = 1'b1;
        end else if (alu_valid) begin
            commit = 1'b1;
            c_rd   = alu_rd;
            c_data = alu_data;
        end else if (!empty) begin
            pop    = 1'b1;
            commit = 1'b1;
        end
    end

    // Load FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= lsu_rd;
            data_mem[wr_ptr] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (commit) begin
            we3 <= (c_rd != 5'd0);
            a3  <= c_rd;
            wd3 <= c_data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // Clear a bit one edge after its write is presented, so the synchronous
    // register file already holds the new value when busy drops; set wins.
    always_comb begin
        clr_mask    = we3 ? (32'd1 << a3) : 32'd0;
        set_mask    = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: commit ordering, FIFO-full priority, x0,
// scoreboard set-wins and asynchronous reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic [31:0] busy;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1'b1; issue_rd = r;
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0; issue_rd = '0;
        #2;
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_a3", 32'(a3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // Single ALU write
        issue(5'd5);
        chk("t1_busy_set", busy, 32'h0000_0020);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h6;
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        chk("t1_we3", 32'(we3), 32'd1);
        chk("t1_a3", 32'(a3), 32'd5);
        chk("t1_wd3", wd3, 32'h6);
        chk("t1_busy_hold", busy, 32'h0000_0020);
        step();
        chk("t1_we3_low", 32'(we3), 32'd0);
        chk("t1_busy_clr", busy, 32'd0);

        // Load behind ALU
        issue(5'd9);
        issue(5'd10);
        chk("t2_busy", busy, 32'h0000_0600);
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h4;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
        step();
        idle();
        chk("t2_c1_a3", 32'(a3), 32'd9);
        chk("t2_c1_wd3", wd3, 32'h4);
        step();
        chk("t2_c2_we3", 32'(we3), 32'd1);
        chk("t2_c2_a3", 32'(a3), 32'd10);
        chk("t2_c2_wd3", wd3, 32'hAA);
        chk("t2_c2_busy", busy, 32'h0000_0400);
        step();
        chk("t2_c3_we3", 32'(we3), 32'd0);
        chk("t2_c3_busy", busy, 32'd0);

        // FIFO full priority: ALU held, 4 loads pushed
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(i);
            lsu_valid = 1'b1; lsu_rd = 5'd11 + 5'(i); lsu_data = 32'h200 + 32'(i);
            chk($sformatf("t3_lsu_ready_%0d", i), 32'(lsu_ready), 32'd1);
            step();
            chk($sformatf("t3_alu_wd3_%0d", i), wd3, 32'h100 + 32'(i));
        end
        lsu_valid = 1'b0;
        alu_data = 32'h104;
        chk("t3_full_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("t3_full_alu_ready", 32'(alu_ready), 32'd0);
        step();
        chk("t3_drain_a3", 32'(a3), 32'd11);
        chk("t3_drain_wd3", wd3, 32'h200);
        chk("t3_alu_ready_back", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("t3_alu_resume", wd3, 32'h104);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("t3_load_a3_%0d", i), 32'(a3), 32'd11 + 32'(i));
            chk($sformatf("t3_load_wd3_%0d", i), wd3, 32'h200 + 32'(i));
        end
        step();
        chk("t3_idle_we3", 32'(we3), 32'd0);

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        chk("t4_alu_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        chk("t4_we3", 32'(we3), 32'd0);
        chk("t4_wd3", wd3, 32'hFFFF_FFFF);
        chk("t4_busy", busy, 32'd0);

        // Scoreboard set-wins
        issue(5'd7);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        chk("t5_we3", 32'(we3), 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk("t5_setwins", busy, 32'h0000_0080);
        step();
        chk("t5_still_busy", busy, 32'h0000_0080);

        // Reset mid-operation: 3 buffered loads, busy = x9|x10
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70 + 32'(i);
            lsu_valid = 1'b1; lsu_rd = 5'd20 + 5'(i); lsu_data = 32'h300 + 32'(i);
            issue_valid = (i < 2); issue_rd = 5'd9 + 5'(i);
            step();
        end
        idle();
        chk("t6_pre_busy", busy, 32'h0000_0600);
        chk("t6_pre_we3", 32'(we3), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we3", 32'(we3), 32'd0);
        chk("t6_rst_busy", busy, 32'd0);
        chk("t6_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("t6_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        rst = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h12;
        step();
        lsu_valid = 1'b0;
        chk("t6_no_early_write", 32'(we3), 32'd0);
        step();
        chk("t6_first_we3", 32'(we3), 32'd1);
        chk("t6_first_a3", 32'(a3), 32'd3);
        chk("t6_first_wd3", wd3, 32'h12);
        step();
        chk("t6_fifo_empty", 32'(we3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
